// File: rtl/aes_cipher_iter_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) helpers.
// Imported by the iterative cipher and its key-round sub-module.
package methods;

  localparam int AES_NB = 4;
  localparam int AES_NK = 4;
  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Byte 0 of the table sits in the top eight bits.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] nb;
    nb = ~b;
    return SBOX[{nb, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]),  sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul2(input logic [7:0] b);
    return xtime(b);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] b);
    return xtime(b) ^ b;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {mul2(a0) ^ mul3(a1) ^ a2 ^ a3,
            a0 ^ mul2(a1) ^ mul3(a2) ^ a3,
            a0 ^ a1 ^ mul2(a2) ^ mul3(a3),
            mul3(a0) ^ a1 ^ a2 ^ mul2(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// Request/result bundle between a host and the iterative AES core.
interface aes_cipher_iter_if;
  logic         start;
  logic [127:0] pt;
  logic [127:0] key;
  logic [127:0] ct;
  logic         busy;
  logic         ready;

  modport master (
    output start, pt, key,
    input  ct, busy, ready
  );

  modport slave (
    input  start, pt, key,
    output ct, busy, ready
  );
endinterface

// File: rtl/aes_cipher_iter_key_round.sv
// One step of the AES-128 key expansion: derives the next
// round key from the current one and the round constant.
module aes_key_round
  import methods::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] t;
  logic [31:0] o0, o1, o2, o3;

  assign {w0, w1, w2, w3} = key_in;
  assign t  = sub_word({w3[23:0], w3[31:24]})
            ^ {rcon, 24'h000000};
  assign o0 = w0 ^ t;
  assign o1 = w1 ^ o0;
  assign o2 = w2 ^ o1;
  assign o3 = w3 ^ o2;
  assign key_out = {o0, o1, o2, o3};

endmodule

// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys
// expanded on the fly, 11-edge latency from start to ready.
module aes_cipher_iter
  import methods::*;
#(
  parameter int Nb = AES_NB,
  parameter int Nk = AES_NK,
  parameter int Nr = AES_NR
) (
  input logic            clk,
  input logic            rst,
  aes_cipher_iter_if.slave bus
);

  localparam int SW = 32 * Nb;
  localparam int KW = 32 * Nk;

  state_e        fsm;
  logic [SW-1:0] st;
  logic [KW-1:0] rk;
  logic [3:0]    rnd;
  logic [127:0]  ct_q;
  logic          busy_q;
  logic          ready_q;

  logic [127:0]  nk;
  logic [127:0]  sb;
  logic [127:0]  sr;
  logic [127:0]  mc;
  logic [127:0]  ns;
  logic          last;

  assign last = (rnd == 4'(Nr));

  aes_key_round u_key (
    .key_in  (rk),
    .rcon    (rcon(rnd)),
    .key_out (nk)
  );

  // Byte i of the state is column i/4, row i%4.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(r+4*c) -: 8] =
          sb[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
    ns = (last ? sr : mc) ^ nk;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fsm     <= IDLE;
      st      <= '0;
      rk      <= '0;
      rnd     <= '0;
      ct_q    <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE, DONE: begin
          if (bus.start) begin
            st      <= bus.pt ^ bus.key;
            rk      <= bus.key;
            rnd     <= 4'd1;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            fsm     <= RUN;
          end
        end
        RUN: begin
          st <= ns;
          rk <= nk;
          if (last) begin
            ct_q    <= ns;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            fsm     <= DONE;
          end else begin
            rnd <= rnd + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.ct    = ct_q;
  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter using FIPS-197 vectors.
module tb_aes_cipher_iter;
  import methods::*;

  localparam logic [127:0] K0   = 128'h0;
  localparam logic [127:0] CT0  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] KC1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTC1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;

  aes_cipher_iter_if bus ();

  aes_cipher_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [127:0] p,
                       input logic [127:0] k,
                       input int poke,
                       input bit scr,
                       output logic [127:0] c,
                       output int lat,
                       output int bc);
    bus.pt = p;
    bus.key = k;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    lat = 1;
    bc = 0;
    while (!bus.ready && lat < 20) begin
      if (bus.busy) bc++;
      bus.start = (lat == poke);
      if (scr) begin
        bus.pt  = {$urandom, $urandom, $urandom, $urandom};
        bus.key = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      lat++;
    end
    bus.start = 1'b0;
    c = bus.ct;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.start = 1'b1;
    bus.pt = PC1;
    bus.key = KC1;
    tick();
    tick();
    checks++;
    if (bus.ct !== 128'h0) begin
      errors++;
      $display("FAIL reset_ct got %h want 0", bus.ct);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got %b want 0", bus.ready);
    end
    bus.start = 1'b0;
    rst = 1'b1;
    tick();
  endtask

  task automatic test_zero();
    logic [127:0] c;
    int lat, bc;
    do_op(K0, K0, -1, 1'b0, c, lat, bc);
    checks++;
    if (c !== CT0) begin
      errors++;
      $display("FAIL zero_ct got %h want %h", c, CT0);
    end
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL zero_latency got %0d want 11", lat);
    end
    checks++;
    if (bc !== 10) begin
      errors++;
      $display("FAIL zero_busy_cycles got %0d want 10", bc);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_busy_done got %b want 0", bus.busy);
    end
  endtask

  task automatic test_c1();
    logic [127:0] c;
    int lat, bc;
    do_op(PC1, KC1, -1, 1'b0, c, lat, bc);
    checks++;
    if (c !== CTC1) begin
      errors++;
      $display("FAIL c1_ct got %h want %h", c, CTC1);
    end
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL c1_latency got %0d want 11", lat);
    end
  endtask

  task automatic test_restart_ignored();
    logic [127:0] c;
    int lat, bc;
    do_op(PB, KB, 5, 1'b0, c, lat, bc);
    checks++;
    if (c !== CTB) begin
      errors++;
      $display("FAIL appb_ct got %h want %h", c, CTB);
    end
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL appb_latency got %0d want 11", lat);
    end
    repeat (3) tick();
    checks++;
    if (bus.ct !== CTB) begin
      errors++;
      $display("FAIL done_hold_ct got %h want %h", bus.ct, CTB);
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL done_hold_ready got %b want 1", bus.ready);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.pt = PC1;
    bus.key = KC1;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (bus.ct !== 128'h0) begin
      errors++;
      $display("FAIL mid_reset_ct got %h want 0", bus.ct);
    end
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready got %b want 0", bus.ready);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_busy got %b want 0", bus.busy);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.ready || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL mid_reset_quiet got %0d active cycles want 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    int low;
    bus.pt = PB;
    bus.key = KB;
    bus.start = 1'b1;
    tick();
    bus.pt = PC1;
    bus.key = KC1;
    n = 1;
    while (!bus.ready && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (bus.ct !== CTB || n !== 11) begin
      errors++;
      $display("FAIL b2b_first got %h at %0d want %h at 11", bus.ct, n, CTB);
    end
    tick();
    bus.start = 1'b0;
    low = 0;
    while (!bus.ready && low < 20) begin
      low++;
      tick();
    end
    checks++;
    if (low !== 10) begin
      errors++;
      $display("FAIL b2b_ready_low got %0d want 10", low);
    end
    checks++;
    if (bus.ct !== CTC1) begin
      errors++;
      $display("FAIL b2b_second_ct got %h want %h", bus.ct, CTC1);
    end
  endtask

  task automatic test_isolation();
    logic [127:0] c;
    int lat, bc;
    do_op(PC1, KC1, -1, 1'b1, c, lat, bc);
    checks++;
    if (c !== CTC1) begin
      errors++;
      $display("FAIL iso_ct got %h want %h", c, CTC1);
    end
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL iso_latency got %0d want 11", lat);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pt = '0;
    bus.key = '0;
    test_reset();
    test_zero();
    test_c1();
    test_restart_ignored();
    test_reset_mid();
    test_back_to_back();
    test_isolation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_cipher_iter.md
AES_CIPHER_ITER -- requirements
Module: aes_cipher_iter

Interface
REQ-001 Parameter Nb, default 4: number of state columns.
REQ-002 Parameter Nk, default 4: number of key words (AES-128).
REQ-003 Parameter Nr, default 10: number of rounds.
REQ-004 The block SHALL use reset rst, synchronous, active-low, and clock clk.
REQ-005 Port clk  input  1  rising-edge clock.
REQ-006 Port rst  input  1  synchronous active-low reset.
REQ-007 Port start  input  1  request to encrypt; sampled only in IDLE or DONE.
REQ-008 Port pt  input  128  plaintext; pt[127:120] is FIPS-197 in[0], pt[7:0] is in[15].
REQ-009 Port key  input  128  cipher key; key[127:120] is key byte 0.
REQ-010 Port ct  output  128  ciphertext; same byte order as pt.
REQ-011 Port busy  output  1  high while rounds are in progress.
REQ-012 Port ready  output  1  high while ct holds a valid result.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-014 In IDLE or DONE, a clock edge with start=1 SHALL capture pt and key, load state = pt XOR key and round key = key, set round counter = 1, clear ready, and enter RUN.
REQ-015 In RUN, each clock edge SHALL perform exactly one round: SubBytes, ShiftRows, MixColumns (omitted when round = Nr), then AddRoundKey with the on-the-fly expanded key for that round.
REQ-016 Round key generation SHALL be iterative: next key is derived from the current key with RotWord, SubWord, and Rcon(round) (01,02,04,08,10,20,40,80,1b,36); no full key schedule is stored.
REQ-017 On the edge that completes round Nr, the FSM SHALL load ct, set ready=1, clear busy, and enter DONE.
REQ-018 Latency SHALL be exactly Nr+1 = 11 edges from the start-sampling edge to the edge on which ready rises.
REQ-019 The round counter SHALL be 4 bits wide, count 1..Nr, and never wrap past Nr.
REQ-020 busy SHALL be 1 exactly in RUN; ready SHALL be 1 exactly in DONE.
REQ-021 start asserted while in RUN SHALL be ignored; the operation in progress SHALL be unaffected and no request SHALL be queued.
REQ-022 ct and ready SHALL stay stable in DONE until start is sampled high or reset occurs.
REQ-023 start=1 in DONE SHALL drop ready on that same edge and begin the new operation (back-to-back, no idle cycle).
REQ-024 pt and key changing after the start-sampling edge SHALL NOT affect the result.
REQ-025 All state changes SHALL occur only on the rising edge of clk.

Reset
REQ-026 With rst=0 at a clock edge, the block SHALL enter IDLE and clear ct, ready, busy, the state register, the round key register, and the round counter to 0.
REQ-027 Reset during RUN SHALL abort the operation; ready SHALL NOT assert for the aborted request.
REQ-028 When rst=0 and start=1 on the same edge, reset SHALL win and start SHALL be ignored.

Structure
REQ-029 The sbox table, the xtime/GF multiply functions, the Rcon function, and the Nb/Nk/Nr constants SHALL reside in the shared package methods, which the block imports.
REQ-030 The FSM state enum SHALL be a typedef in methods.
REQ-031 Next-round-key generation SHALL be one combinational sub-module, aes_key_round, with inputs (key_in[127:0], rcon[7:0]) and output key_out[127:0].
REQ-032 The round datapath SHALL be combinational from the state and round key registers to the next-state register; it SHALL contain one round instance only, with no unrolling.

Verification
REQ-033 Zero vector: key=0, pt=0, start for 1 cycle -> ready after 11 edges, ct=66e94bd4ef8a2c3b884cfa59ca342b2e, busy high for 10 cycles.
REQ-034 FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f, pt=00112233445566778899aabbccddeeff -> ct=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-035 FIPS-197 App. B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734 -> ct=3925841d02dc09fbdc118597196a0b32; start pulsed again in RUN cycle 5 -> same ct and same latency.
REQ-036 Reset mid-operation: start the C.1 vector, drive rst=0 in RUN cycle 4 -> next edge ct=0, ready=0, busy=0; no ready assertion follows.
REQ-037 Back-to-back: start held high across DONE with the App. B vector then the C.1 vector -> ready falls for exactly 10 cycles and the second ct=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-038 Input isolation: change pt and key every cycle after the start-sampling edge -> ct equals the value for the sampled inputs.
